// File: rtl/mmm_bit_collector_pkg.sv
// Shared definitions for the bit collector: FSM state encoding and the default word width.
package mmm_bit_collector_pkg;

  localparam int MMM_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/mmm_bit_collector_if.sv
// Control, serial-in and word-out handshake bundle for the bit collector.
interface mmm_bit_collector_if
  import mmm_bit_collector_pkg::*;
#(
  parameter int WIDTH = MMM_WIDTH
);

  logic             clr;
  logic             en;
  logic             start;
  logic             bit_i;
  logic             ready_i;
  logic [WIDTH-1:0] word_o;
  logic             valid_o;
  logic             busy_o;
  logic             overrun_o;

  // master: bit source plus consumer; slave: the collector itself
  modport master (
    output clr, en, start, bit_i, ready_i,
    input  word_o, valid_o, busy_o, overrun_o
  );

  modport slave (
    input  clr, en, start, bit_i, ready_i,
    output word_o, valid_o, busy_o, overrun_o
  );

endinterface

// File: rtl/mmm_bit_collector.sv
// Serial-in/parallel-out collector: gathers WIDTH bits LSB first on enabled cycles and
// holds the assembled word behind a valid/ready handshake.
module mmm_bit_collector
  import mmm_bit_collector_pkg::*;
#(
  parameter int WIDTH = MMM_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rstb,
  mmm_bit_collector_if.slave bus
);

  state_e             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [WIDTH-1:0]   sr_q,      sr_d;
  logic [WIDTH-1:0]   word_q,    word_d;
  logic               valid_q,   valid_d;
  logic               overrun_q, overrun_d;
  logic [WIDTH-1:0]   shift_in;

  // New bit enters at the top, so after WIDTH shifts the first bit sits in bit 0.
  assign shift_in = {bus.bit_i, sr_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (bus.clr) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      sr_d      = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
            sr_d    = '0;
          end
        end

        ST_SHIFT: begin
          // A restart wins over a capture landing in the same cycle.
          if (bus.start) begin
            cnt_d = '0;
            sr_d  = '0;
          end else if (bus.en) begin
            sr_d = shift_in;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              word_d  = shift_in;
              valid_d = 1'b1;
              cnt_d   = '0;
              state_d = ST_HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end

        ST_HOLD: begin
          if (bus.ready_i) begin
            valid_d = 1'b0;
            if (bus.start) begin
              state_d = ST_SHIFT;
              cnt_d   = '0;
              sr_d    = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (bus.start) begin
            overrun_d = 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.word_o    = word_q;
  assign bus.valid_o   = valid_q;
  assign bus.busy_o    = (state_q == ST_SHIFT);
  assign bus.overrun_o = overrun_q;

endmodule

// File: tb/tb_mmm_bit_collector.sv
// Self-checking bench for mmm_bit_collector: directed scenarios plus randomized frames
// checked against word values computed from the serial bit order.
module tb_mmm_bit_collector;

  localparam int WIDTH = 10;
  localparam int CNT_W = 4;

  logic clk;
  logic rstb;
  int   n_checks;
  int   n_fail;

  mmm_bit_collector_if #(.WIDTH(WIDTH)) bus ();

  mmm_bit_collector #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rstb(rstb),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  // Feeds w LSB first; mode 0: en always on, 1: en toggles, 2: en random.
  task automatic feed_bits(input logic [WIDTH-1:0] w, input int mode, input string tag);
    int idx;
    int guard;
    bit tog;
    idx   = 0;
    guard = 0;
    tog   = 1'b1;
    while (idx < WIDTH && guard < 200) begin
      case (mode)
        0:       bus.en = 1'b1;
        1:       bus.en = tog;
        default: bus.en = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      bus.bit_i = bus.en ? w[idx] : 1'($urandom_range(0, 1));
      cycle();
      guard++;
      if (bus.en) idx++;
      if (idx < WIDTH) begin
        n_checks++;
        if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_midframe: valid=%b busy=%b after %0d captures, required valid=0 busy=1",
                   tag, bus.valid_o, bus.busy_o, idx);
        end
      end
    end
    bus.en = 1'b0;
    n_checks++;
    if (idx != WIDTH) begin
      n_fail++;
      $display("FAIL %s_timeout: only %0d captures in %0d cycles, required %0d", tag, idx, guard, WIDTH);
    end
    n_checks++;
    if (bus.valid_o !== 1'b1 || bus.word_o !== w || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_word: valid=%b busy=%b word=%h, required valid=1 busy=0 word=%h",
               tag, bus.valid_o, bus.busy_o, bus.word_o, w);
    end
    $display("frame %s: word=%h expected=%h cycles=%0d", tag, bus.word_o, w, guard);
  endtask

  task automatic accept(input bit b2b, input logic [WIDTH-1:0] w, input string tag);
    bus.ready_i = 1'b1;
    bus.start   = b2b;
    cycle();
    bus.ready_i = 1'b0;
    bus.start   = 1'b0;
    n_checks++;
    if (bus.valid_o !== 1'b0 || bus.busy_o !== b2b || bus.word_o !== w) begin
      n_fail++;
      $display("FAIL %s_accept: valid=%b busy=%b word=%h, required valid=0 busy=%b word=%h",
               tag, bus.valid_o, bus.busy_o, bus.word_o, b2b, w);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.word_o !== '0 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.overrun_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: word=%h valid=%b busy=%b overrun=%b, required all 0",
               bus.word_o, bus.valid_o, bus.busy_o, bus.overrun_o);
    end
    rstb = 1'b1;
    bus.en    = 1'b1;
    bus.bit_i = 1'b1;
    repeat (3) cycle();
    bus.en = 1'b0;
    n_checks++;
    if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b valid=%b with en but no start, required 0 0",
               bus.busy_o, bus.valid_o);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_basic();
    pulse_start();
    feed_bits(10'h2A5, 0, "basic");
    accept(1'b0, 10'h2A5, "basic");
  endtask

  task automatic test_en_toggle();
    pulse_start();
    feed_bits(10'h2A5, 1, "en_toggle");
    accept(1'b0, 10'h2A5, "en_toggle");
  endtask

  task automatic test_overrun();
    pulse_start();
    feed_bits(10'h0C3, 0, "overrun");
    pulse_start();
    n_checks++;
    if (bus.overrun_o !== 1'b1 || bus.valid_o !== 1'b1 || bus.word_o !== 10'h0C3 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_set: overrun=%b valid=%b busy=%b word=%h, required 1 1 0 0c3",
               bus.overrun_o, bus.valid_o, bus.busy_o, bus.word_o);
    end
    bus.clr = 1'b1;
    cycle();
    bus.clr = 1'b0;
    cycle();
    n_checks++;
    if (bus.overrun_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clr: overrun=%b valid=%b busy=%b, required 0 0 0",
               bus.overrun_o, bus.valid_o, bus.busy_o);
    end
    $display("overrun: flag=%b after clr", bus.overrun_o);
  endtask

  task automatic test_back_to_back();
    pulse_start();
    feed_bits(10'h2A5, 0, "b2b_first");
    accept(1'b1, 10'h2A5, "b2b_first");
    feed_bits(10'h155, 0, "b2b_second");
    accept(1'b0, 10'h155, "b2b_second");
  endtask

  task automatic test_abort();
    pulse_start();
    bus.en    = 1'b1;
    bus.bit_i = 1'b0;
    repeat (4) cycle();
    bus.start = 1'b1;
    bus.bit_i = 1'b0;
    cycle();
    bus.start = 1'b0;
    bus.en    = 1'b0;
    n_checks++;
    if (bus.busy_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_restart: busy=%b valid=%b, required 1 0", bus.busy_o, bus.valid_o);
    end
    feed_bits(10'h3FF, 0, "abort");
    accept(1'b0, 10'h3FF, "abort");
  endtask

  task automatic test_reset_mid();
    pulse_start();
    bus.en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.bit_i = 1'($urandom_range(0, 1));
      cycle();
    end
    bus.en = 1'b0;
    rstb = 1'b0;
    #1;
    n_checks++;
    if (bus.word_o !== '0 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.overrun_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: word=%h valid=%b busy=%b overrun=%b, required all 0",
               bus.word_o, bus.valid_o, bus.busy_o, bus.overrun_o);
    end
    cycle();
    rstb   = 1'b1;
    bus.en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus.bit_i = 1'($urandom_range(0, 1));
      cycle();
      n_checks++;
      if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release: cycle %0d valid=%b busy=%b, required 0 0", i, bus.valid_o, bus.busy_o);
      end
    end
    bus.en = 1'b0;
    $display("reset_mid: partial frame discarded");
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] w;
    bit in_shift;
    bit b2b;
    int d;
    in_shift = 1'b0;
    for (int k = 0; k < 12; k++) begin
      w = WIDTH'($urandom);
      if (!in_shift) pulse_start();
      feed_bits(w, 2, "random");
      d = $urandom_range(0, 3);
      for (int j = 0; j < d; j++) begin
        bus.en    = 1'($urandom_range(0, 1));
        bus.bit_i = 1'($urandom_range(0, 1));
        cycle();
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.word_o !== w) begin
          n_fail++;
          $display("FAIL random_hold: valid=%b word=%h, required 1 %h", bus.valid_o, bus.word_o, w);
        end
      end
      bus.en = 1'b0;
      b2b = 1'($urandom_range(0, 1));
      accept(b2b, w, "random");
      in_shift = b2b;
    end
    if (in_shift) begin
      feed_bits(10'h001, 0, "random_tail");
      accept(1'b0, 10'h001, "random_tail");
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rstb        = 1'b0;
    bus.clr     = 1'b0;
    bus.en      = 1'b0;
    bus.start   = 1'b0;
    bus.bit_i   = 1'b0;
    bus.ready_i = 1'b0;
    #12;
    test_reset();
    test_basic();
    test_en_toggle();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
